// File: rtl/branch_cmp_seq.sv
// Slice-serial branch comparator: scans operands MSB slice first, stopping at the
// first differing slice, and registers eq/lt/ltu plus the funct3-decoded branch decision.

module branch_cmp_slice #(
    parameter int CHUNK    = 8,
    parameter bit SIGN_FIX = 1'b0
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             diff,
    output logic             lt,
    output logic             ltu
);
    // Flipping the top bit turns a two's-complement compare into an unsigned one.
    localparam logic [CHUNK-1:0] SMASK = SIGN_FIX ? (CHUNK'(1) << (CHUNK-1)) : '0;

    assign diff = (a != b);
    assign ltu  = (a < b);
    assign lt   = ((a ^ SMASK) < (b ^ SMASK));
endmodule

module branch_cmp_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    input  logic [2:0]       funct3,
    output logic             busy,
    output logic             done,
    output logic             br_eq,
    output logic             br_lt,
    output logic             br_ltu,
    output logic             br_taken
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

    generate
        if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_param
            $error("branch_cmp_seq: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    typedef enum logic {IDLE, SCAN} state_t;

    typedef struct packed {
        logic [NCH-1:0][CHUNK-1:0] a;
        logic [NCH-1:0][CHUNK-1:0] b;
        logic [2:0]                f3;
    } req_t;

    state_t         state;
    req_t           req;
    logic [IW-1:0]  idx;
    logic [NCH-1:0] sl_diff, sl_lt, sl_ltu;
    logic           cur_diff, cur_lt, cur_ltu;

    genvar g;
    generate
        for (g = 0; g < NCH; g++) begin : g_slice
            branch_cmp_slice #(
                .CHUNK   (CHUNK),
                .SIGN_FIX(g == NCH-1)
            ) u_slice (
                .a   (req.a[g]),
                .b   (req.b[g]),
                .diff(sl_diff[g]),
                .lt  (sl_lt[g]),
                .ltu (sl_ltu[g])
            );
        end
    endgenerate

    always_comb begin
        cur_diff = sl_diff[idx];
        cur_lt   = sl_lt[idx];
        cur_ltu  = sl_ltu[idx];
    end

    function automatic logic taken_of(input logic [2:0] f3, input logic eq,
                                      input logic lt, input logic ltu);
        logic t;
        case (f3)
            3'b000:  t = eq;
            3'b001:  t = !eq;
            3'b100:  t = lt;
            3'b101:  t = !lt;
            3'b110:  t = ltu;
            3'b111:  t = !ltu;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            req      <= '0;
            idx      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            br_eq    <= 1'b0;
            br_lt    <= 1'b0;
            br_ltu   <= 1'b0;
            br_taken <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        req.a  <= rs1;
                        req.b  <= rs2;
                        req.f3 <= funct3;
                        idx    <= IW'(NCH-1);
                        busy   <= 1'b1;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    // Abort wins over a completion landing on the same edge.
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cur_diff) begin
                        br_eq    <= 1'b0;
                        br_lt    <= cur_lt;
                        br_ltu   <= cur_ltu;
                        br_taken <= taken_of(req.f3, 1'b0, cur_lt, cur_ltu);
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else if (idx == '0) begin
                        br_eq    <= 1'b1;
                        br_lt    <= 1'b0;
                        br_ltu   <= 1'b0;
                        br_taken <= taken_of(req.f3, 1'b1, 1'b0, 1'b0);
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_branch_cmp_seq.sv
// Randomised bench for branch_cmp_seq against a plain-arithmetic comparison model.

module tb_branch_cmp_seq;
    localparam int WIDTH = 32;
    localparam int CHUNK = 8;
    localparam int NCH   = WIDTH / CHUNK;

    logic              CLK = 1'b0, RST = 1'b1, start = 1'b0, flush = 1'b0;
    logic [WIDTH-1:0]  rs1 = '0, rs2 = '0;
    logic [2:0]        funct3 = '0;
    logic              busy, done, br_eq, br_lt, br_ltu, br_taken;

    int errors = 0, checks = 0;
    bit m_eq, m_lt, m_ltu, m_tk;

    branch_cmp_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .CLK(CLK), .RST(RST), .start(start), .flush(flush),
        .rs1(rs1), .rs2(rs2), .funct3(funct3),
        .busy(busy), .done(done), .br_eq(br_eq), .br_lt(br_lt),
        .br_ltu(br_ltu), .br_taken(br_taken)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slices examined before a decision: first differing slice from the top, else all.
    function automatic int model_lat(input bit [31:0] a, input bit [31:0] b);
        for (int s = NCH-1; s >= 0; s--)
            if (((a >> (s*CHUNK)) & 32'hFF) != ((b >> (s*CHUNK)) & 32'hFF))
                return NCH - s;
        return NCH;
    endfunction

    function automatic bit model_taken(input bit [2:0] f, input bit eq, input bit lt, input bit ltu);
        case (f)
            3'd0: return eq;
            3'd1: return !eq;
            3'd4: return lt;
            3'd5: return !lt;
            3'd6: return ltu;
            3'd7: return !ltu;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] flags();
        return {br_eq, br_lt, br_ltu, br_taken};
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge where done is seen.
    task automatic run_cmp(input bit [31:0] a, input bit [31:0] b, input bit [2:0] f,
                           input bit poke, input bit fl);
        int lat, cyc;
        lat = model_lat(a, b);
        rs1 = a; rs2 = b; funct3 = f; start = 1'b1; flush = fl;
        @(negedge CLK);
        start = 1'b0; flush = 1'b0;
        chk("busy_accept", busy, 1);
        chk("done_accept", done, 0);
        if (poke) begin
            start = 1'b1; rs1 = ~a; rs2 = a ^ 32'h5A5A5A5A; funct3 = ~f;
        end
        cyc = 0;
        while (!done && cyc < NCH + 4) begin
            @(negedge CLK);
            cyc++;
            start = 1'b0;
            if (!done) chk("flags_hold_scan", flags(), {m_eq, m_lt, m_ltu, m_tk});
        end
        chk("latency", cyc, lat);
        m_eq  = (a == b);
        m_lt  = ($signed(a) < $signed(b));
        m_ltu = (a < b);
        m_tk  = model_taken(f, m_eq, m_lt, m_ltu);
        chk("flags", flags(), {m_eq, m_lt, m_ltu, m_tk});
        chk("busy_done", busy, 0);
    endtask

    initial begin
        bit [31:0] a, b, mask;
        int m;

        repeat (2) @(negedge CLK);
        chk("reset_outs", {busy, done, br_eq, br_lt, br_ltu, br_taken}, 0);
        m_eq = 0; m_lt = 0; m_ltu = 0; m_tk = 0;
        RST = 1'b0;
        @(negedge CLK);

        run_cmp(32'h12345678, 32'h12345678, 3'b000, 0, 0);
        run_cmp(32'h12345678, 32'h12345678, 3'b001, 0, 0);
        run_cmp(32'h80000000, 32'h00000001, 3'b100, 0, 0);
        run_cmp(32'h80000000, 32'h00000001, 3'b110, 0, 0);
        run_cmp(32'h000000FF, 32'h00000100, 3'b111, 0, 0);
        run_cmp(32'h00000000, 32'h00000000, 3'b010, 0, 0);
        run_cmp(32'h7F00AA00, 32'hFF00AA01, 3'b101, 1, 0);
        run_cmp(32'h00000001, 32'h00000000, 3'b011, 1, 0);
        // done cycle of the previous call doubles as a flush-in-IDLE acceptance
        run_cmp(32'hAB000000, 32'hAB000001, 3'b110, 0, 1);

        // Abort one cycle into an equal-operand scan
        rs1 = 32'hCAFEF00D; rs2 = 32'hCAFEF00D; funct3 = 3'b000; start = 1'b1;
        @(negedge CLK);
        start = 1'b0; flush = 1'b1;
        @(negedge CLK);
        flush = 1'b0;
        chk("flush_busy", busy, 0);
        chk("flush_done", done, 0);
        chk("flush_flags", flags(), {m_eq, m_lt, m_ltu, m_tk});
        repeat (NCH + 1) begin
            @(negedge CLK);
            chk("flush_no_done", done, 0);
        end

        // Abort on the same edge as a latency-1 completion
        rs1 = 32'h80000000; rs2 = 32'h00000001; funct3 = 3'b100; start = 1'b1;
        @(negedge CLK);
        start = 1'b0; flush = 1'b1;
        @(negedge CLK);
        flush = 1'b0;
        chk("flush_prio_done", done, 0);
        chk("flush_prio_busy", busy, 0);
        chk("flush_prio_flags", flags(), {m_eq, m_lt, m_ltu, m_tk});

        // Reset mid-scan
        rs1 = 32'h12345678; rs2 = 32'h12345678; funct3 = 3'b000; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("rst_mid_outs", {busy, done, br_eq, br_lt, br_ltu, br_taken}, 0);
        m_eq = 0; m_lt = 0; m_ltu = 0; m_tk = 0;
        @(negedge CLK);
        RST = 1'b0;
        repeat (NCH + 1) begin
            @(negedge CLK);
            chk("rst_no_done", {busy, done}, 0);
        end

        run_cmp(32'h00000000, 32'h00000000, 3'b010, 0, 0);

        for (int i = 0; i < 60; i++) begin
            a = $urandom; b = $urandom;
            m = $urandom_range(0, NCH);
            if (m == NCH) b = a;
            else if (m > 0) begin
                mask = 32'hFFFFFFFF << (32 - CHUNK*m);
                b = (b & ~mask) | (a & mask);
            end
            if ($urandom_range(0, 3) == 0) begin
                @(negedge CLK);
                chk("idle_done", done, 0);
            end
            run_cmp(a, b, 3'($urandom_range(0, 7)), $urandom_range(0, 3) == 0,
                    $urandom_range(0, 3) == 0);
        end

        @(negedge CLK);
        chk("final_done_low", done, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
